// File: rtl/rs_issue_latch.sv
// RS issue latch: drives the rotating selector, turns its one-hot grant into an
// index, and queues the granted payload in a 2-deep FIFO feeding one FU.
module rs_issue_latch #(
  parameter int N_ENTRY = 8,
  parameter int DATA_W  = 64,
  parameter int IDX_W   = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_ENTRY-1:0]          gnt,
  input  logic [N_ENTRY*DATA_W-1:0]   entry_data,
  input  logic                        fu_ready,
  output logic                        sel_en,
  output logic [IDX_W-1:0]            sel_cnt,
  output logic [N_ENTRY-1:0]          entry_clear,
  output logic                        issue_valid,
  output logic [IDX_W-1:0]            issue_idx,
  output logic [DATA_W-1:0]           issue_data,
  output logic                        gnt_err
);

  logic [1:0]        count_q, count_d;
  logic              head_q, head_d;
  logic [IDX_W-1:0]  slot_idx_q [2];
  logic [IDX_W-1:0]  slot_idx_d [2];
  logic [DATA_W-1:0] slot_data_q [2];
  logic [DATA_W-1:0] slot_data_d [2];
  logic [IDX_W-1:0]  sel_cnt_q, sel_cnt_d;
  logic              gnt_err_q, gnt_err_d;

  logic [IDX_W:0]    gnt_ones;
  logic [IDX_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  logic              onehot;
  logic              multi;
  logic              accept;
  logic              deq;
  logic              tail;

  // Population count, binary encode and payload mux of the grant vector.
  always_comb begin
    gnt_ones = '0;
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      gnt_ones = gnt_ones + {{IDX_W{1'b0}}, gnt[i]};
      if (gnt[i]) begin
        gnt_idx  = IDX_W'(i);
        gnt_data = entry_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign onehot      = (gnt_ones == (IDX_W+1)'(1));
  assign multi       = (gnt_ones > (IDX_W+1)'(1));
  assign sel_en      = ~reset && (count_q != 2'd2);
  assign accept      = sel_en && onehot;
  assign entry_clear = accept ? gnt : '0;
  assign issue_valid = (count_q != 2'd0);
  assign deq         = issue_valid && fu_ready;
  // Tail sits one past the head when a packet is already queued.
  assign tail        = head_q ^ count_q[0];

  assign issue_idx   = slot_idx_q[head_q];
  assign issue_data  = slot_data_q[head_q];
  assign sel_cnt     = sel_cnt_q;
  assign gnt_err     = gnt_err_q;

  always_comb begin
    count_d     = count_q + {1'b0, accept} - {1'b0, deq};
    head_d      = head_q ^ deq;
    slot_idx_d  = slot_idx_q;
    slot_data_d = slot_data_q;
    sel_cnt_d   = sel_cnt_q + IDX_W'(accept);
    gnt_err_d   = multi || ((gnt != '0) && !sel_en);
    if (accept) begin
      slot_idx_d[tail]  = gnt_idx;
      slot_data_d[tail] = gnt_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      head_q    <= 1'b0;
      sel_cnt_q <= '0;
      gnt_err_q <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        slot_idx_q[s]  <= '0;
        slot_data_q[s] <= '0;
      end
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      sel_cnt_q <= sel_cnt_d;
      gnt_err_q <= gnt_err_d;
      for (int s = 0; s < 2; s++) begin
        slot_idx_q[s]  <= slot_idx_d[s];
        slot_data_q[s] <= slot_data_d[s];
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_latch.sv
// Scoreboard bench for rs_issue_latch: a queue-based model predicts every
// output; a monitor checks issued packets against the expected-packet queue.
module tb_rs_issue_latch;

  localparam int N_ENTRY = 8;
  localparam int DATA_W  = 64;
  localparam int IDX_W   = 3;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } pkt_t;

  logic                      clock;
  logic                      reset;
  logic [N_ENTRY-1:0]        gnt;
  logic [N_ENTRY*DATA_W-1:0] entry_data;
  logic                      fu_ready;
  logic                      sel_en;
  logic [IDX_W-1:0]          sel_cnt;
  logic [N_ENTRY-1:0]        entry_clear;
  logic                      issue_valid;
  logic [IDX_W-1:0]          issue_idx;
  logic [DATA_W-1:0]         issue_data;
  logic                      gnt_err;

  int checks = 0;
  int errors = 0;

  pkt_t exp_q [$];
  int   model_count = 0;
  int   model_sel_cnt = 0;
  bit   model_err = 1'b0;

  rs_issue_latch #(.N_ENTRY(N_ENTRY), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .gnt         (gnt),
    .entry_data  (entry_data),
    .fu_ready    (fu_ready),
    .sel_en      (sel_en),
    .sel_cnt     (sel_cnt),
    .entry_clear (entry_clear),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_data  (issue_data),
    .gnt_err     (gnt_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predicts this cycle's outputs from the model, then advances the model one clock.
  task automatic checkOutput();
    int   ones;
    int   idx;
    bit   exp_sel_en;
    bit   acc;
    bit   deq;
    pkt_t p;
    ones = $countones(gnt);
    exp_sel_en = !reset && (model_count != 2);
    acc = exp_sel_en && (ones == 1);
    compare("sel_en", 64'(sel_en), 64'(exp_sel_en));
    compare("entry_clear", 64'(entry_clear), acc ? 64'(gnt) : 64'd0);
    compare("sel_cnt", 64'(sel_cnt), 64'(model_sel_cnt));
    compare("gnt_err", 64'(gnt_err), 64'(model_err));
    compare("issue_valid", 64'(issue_valid), 64'(model_count != 0));
    if (reset) begin
      model_count   = 0;
      model_sel_cnt = 0;
      model_err     = 1'b0;
      exp_q.delete();
    end else begin
      deq = (model_count != 0) && fu_ready;
      if (acc) begin
        idx = 0;
        for (int i = 0; i < N_ENTRY; i++) if (gnt[i]) idx = i;
        p.idx  = IDX_W'(idx);
        p.data = entry_data[idx*DATA_W +: DATA_W];
        exp_q.push_back(p);
      end
      model_count   = model_count + int'(acc) - int'(deq);
      model_sel_cnt = (model_sel_cnt + int'(acc)) % N_ENTRY;
      model_err     = (ones >= 2) || ((ones != 0) && !exp_sel_en);
    end
  endtask

  // One clock of stimulus; fix_idx >= 0 pins that entry's payload to fix_val.
  task automatic applyStimulus(input logic r, input logic [N_ENTRY-1:0] g, input logic fr,
                               input int fix_idx = -1, input logic [DATA_W-1:0] fix_val = '0);
    @(posedge clock);
    #1;
    reset    = r;
    gnt      = g;
    fu_ready = fr;
    for (int i = 0; i < N_ENTRY; i++)
      entry_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
    if (fix_idx >= 0) entry_data[fix_idx*DATA_W +: DATA_W] = fix_val;
    #3;
    checkOutput();
  endtask

  // Monitor: every cycle the DUT presents a head packet it must match the oldest expected one.
  initial begin
    pkt_t h;
    forever begin
      @(negedge clock);
      if (!reset && issue_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL issue_unexpected: got idx %0d expected no packet at %0t", issue_idx, $time);
        end else begin
          h = exp_q[0];
          compare("issue_idx", 64'(issue_idx), 64'(h.idx));
          compare("issue_data", issue_data, h.data);
          if (fu_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int r;
    reset      = 1'b1;
    gnt        = '0;
    fu_ready   = 1'b0;
    entry_data = '0;

    applyStimulus(1, 8'h00, 0);
    applyStimulus(1, 8'h00, 0);

    // Single grant of entry 2 with a known payload.
    applyStimulus(0, 8'b0000_0100, 1, 2, 64'hA5);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1);

    // Fill to two with fu_ready low, reject a third grant, then drain.
    applyStimulus(0, 8'h20, 0);
    applyStimulus(0, 8'h02, 0);
    applyStimulus(0, 8'h01, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1);

    // Simultaneous enqueue and dequeue at occupancy one.
    applyStimulus(0, 8'h10, 0);
    applyStimulus(0, 8'h80, 1);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 1);

    // Two bits set is a protocol error.
    applyStimulus(0, 8'b0001_0010, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 0);

    // Nine back-to-back grants to wrap sel_cnt.
    for (int k = 0; k < 9; k++)
      applyStimulus(0, 8'(1 << $urandom_range(0, 7)), 1);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1);

    // Reset while full and stalled.
    applyStimulus(0, 8'h08, 0);
    applyStimulus(0, 8'h40, 0);
    applyStimulus(1, 8'h04, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 1);

    // Randomized traffic with occasional mid-run reset.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      applyStimulus(($urandom_range(0, 49) == 0),
                    (r < 3) ? 8'h00 :
                    (r < 8) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom),
                    ($urandom_range(0, 2) != 0));
    end
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
